// File: rtl/dff_rp_response_checker_if.sv
// Stimulus and result bundle between a DFF bench and its response checker.
// No handshake: the checker samples every signal on each rising clk edge while a session runs.
interface dff_rp_response_checker_if #(
    parameter int CNT_W = 16
);
    logic             enable_in;
    logic             d_in;
    logic             dut_reset_al_in;
    logic             dut_preset_in;
    logic             q_in;
    logic             busy_out;
    logic             pass_out;
    logic             fail_out;
    logic             expected_q_out;
    logic [CNT_W-1:0] check_count_out;
    logic [CNT_W-1:0] err_count_out;
    logic [CNT_W-1:0] first_err_cycle_out;
    logic [1:0]       state_dbg;

    modport master (
        output enable_in, d_in, dut_reset_al_in, dut_preset_in, q_in,
        input  busy_out, pass_out, fail_out, expected_q_out,
        input  check_count_out, err_count_out, first_err_cycle_out, state_dbg
    );

    modport slave (
        input  enable_in, d_in, dut_reset_al_in, dut_preset_in, q_in,
        output busy_out, pass_out, fail_out, expected_q_out,
        output check_count_out, err_count_out, first_err_cycle_out, state_dbg
    );
endinterface

// File: rtl/dff_rp_response_checker.sv
// Response checker for a DFF with active-low reset and active-high preset:
// runs a reference model one edge ahead of the observed q and keeps saturating statistics.
module dff_rp_response_checker #(
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0,
    parameter int RESET_PRIO   = 1
) (
    input logic                       clk,
    input logic                       reset_in,
    dff_rp_response_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic             exp_q, exp_nx, model_d;
    logic             valid_q, valid_nx;
    logic             fail_q, fail_nx;
    logic             busy_q, busy_nx;
    logic             pass_q, pass_nx;
    logic             mismatch;
    logic [CNT_W-1:0] chk_q, chk_nx;
    logic [CNT_W-1:0] err_q, err_nx;
    logic [CNT_W-1:0] first_q, first_nx;

    // Next value the DUT must hold after this edge; priority decides the reset+preset case.
    always_comb begin
        model_d = bus.d_in;
        if (!bus.dut_reset_al_in && (RESET_PRIO != 0 || !bus.dut_preset_in))
            model_d = 1'b0;
        else if (bus.dut_preset_in)
            model_d = 1'b1;
    end

    assign mismatch = (bus.q_in != exp_q);

    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        valid_nx = valid_q;
        fail_nx  = fail_q;
        chk_nx   = chk_q;
        err_nx   = err_q;
        first_nx = first_q;
        case (state)
            IDLE: begin
                if (bus.enable_in) state_nx = PRIME;
            end
            PRIME: begin
                chk_nx   = '0;
                err_nx   = '0;
                first_nx = '0;
                fail_nx  = 1'b0;
                exp_nx   = model_d;
                valid_nx = 1'b1;
                state_nx = bus.enable_in ? CHECK : IDLE;
            end
            CHECK: begin
                exp_nx = model_d;
                if (!bus.enable_in) begin
                    state_nx = DONE;
                end else if (valid_q) begin
                    chk_nx = (chk_q == CNT_MAX) ? chk_q : chk_q + CNT_ONE;
                    if (mismatch) begin
                        err_nx = (err_q == CNT_MAX) ? err_q : err_q + CNT_ONE;
                        if (!fail_q) begin
                            first_nx = chk_q;
                            fail_nx  = 1'b1;
                        end
                        if (STOP_ON_FAIL != 0) state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.enable_in) state_nx = PRIME;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == PRIME) || (state_nx == CHECK);
        pass_nx = (state_nx == DONE) && (err_nx == '0);
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state   <= IDLE;
            exp_q   <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            chk_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state   <= state_nx;
            exp_q   <= exp_nx;
            valid_q <= valid_nx;
            fail_q  <= fail_nx;
            busy_q  <= busy_nx;
            pass_q  <= pass_nx;
            chk_q   <= chk_nx;
            err_q   <= err_nx;
            first_q <= first_nx;
        end
    end

    assign bus.busy_out            = busy_q;
    assign bus.pass_out            = pass_q;
    assign bus.fail_out            = fail_q;
    assign bus.expected_q_out      = exp_q;
    assign bus.check_count_out     = chk_q;
    assign bus.err_count_out       = err_q;
    assign bus.first_err_cycle_out = first_q;
    assign bus.state_dbg           = state;
endmodule

// File: tb/tb_dff_rp_response_checker.sv
// Bench for dff_rp_response_checker: four parameterisations share one stimulus stream,
// each compared every cycle against a behavioural model plus a few literal expectations.
module tb_dff_rp_response_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic en = 1'b0, d = 1'b0, ral = 1'b1, pre = 1'b0;
    logic qv [4];
    int   errors = 0, checks = 0;
    bit   running = 1'b1;

    dff_rp_response_checker_if #(.CNT_W(16)) if0 ();
    dff_rp_response_checker_if #(.CNT_W(16)) if1 ();
    dff_rp_response_checker_if #(.CNT_W(16)) if2 ();
    dff_rp_response_checker_if #(.CNT_W(4))  if3 ();

    dff_rp_response_checker #(.CNT_W(16), .STOP_ON_FAIL(0), .RESET_PRIO(1)) u0 (.clk(clk), .reset_in(rst), .bus(if0.slave));
    dff_rp_response_checker #(.CNT_W(16), .STOP_ON_FAIL(0), .RESET_PRIO(0)) u1 (.clk(clk), .reset_in(rst), .bus(if1.slave));
    dff_rp_response_checker #(.CNT_W(16), .STOP_ON_FAIL(1), .RESET_PRIO(1)) u2 (.clk(clk), .reset_in(rst), .bus(if2.slave));
    dff_rp_response_checker #(.CNT_W(4),  .STOP_ON_FAIL(0), .RESET_PRIO(1)) u3 (.clk(clk), .reset_in(rst), .bus(if3.slave));

    assign if0.enable_in = en;  assign if0.d_in = d;  assign if0.dut_reset_al_in = ral;  assign if0.dut_preset_in = pre;  assign if0.q_in = qv[0];
    assign if1.enable_in = en;  assign if1.d_in = d;  assign if1.dut_reset_al_in = ral;  assign if1.dut_preset_in = pre;  assign if1.q_in = qv[1];
    assign if2.enable_in = en;  assign if2.d_in = d;  assign if2.dut_reset_al_in = ral;  assign if2.dut_preset_in = pre;  assign if2.q_in = qv[2];
    assign if3.enable_in = en;  assign if3.d_in = d;  assign if3.dut_reset_al_in = ral;  assign if3.dut_preset_in = pre;  assign if3.q_in = qv[3];

    logic        o_busy [4], o_pass [4], o_fail [4], o_exp [4];
    logic [31:0] o_chk [4], o_err [4], o_first [4];
    assign o_busy[0] = if0.busy_out;  assign o_pass[0] = if0.pass_out;  assign o_fail[0] = if0.fail_out;  assign o_exp[0] = if0.expected_q_out;
    assign o_busy[1] = if1.busy_out;  assign o_pass[1] = if1.pass_out;  assign o_fail[1] = if1.fail_out;  assign o_exp[1] = if1.expected_q_out;
    assign o_busy[2] = if2.busy_out;  assign o_pass[2] = if2.pass_out;  assign o_fail[2] = if2.fail_out;  assign o_exp[2] = if2.expected_q_out;
    assign o_busy[3] = if3.busy_out;  assign o_pass[3] = if3.pass_out;  assign o_fail[3] = if3.fail_out;  assign o_exp[3] = if3.expected_q_out;
    assign o_chk[0] = 32'(if0.check_count_out);  assign o_err[0] = 32'(if0.err_count_out);  assign o_first[0] = 32'(if0.first_err_cycle_out);
    assign o_chk[1] = 32'(if1.check_count_out);  assign o_err[1] = 32'(if1.err_count_out);  assign o_first[1] = 32'(if1.first_err_cycle_out);
    assign o_chk[2] = 32'(if2.check_count_out);  assign o_err[2] = 32'(if2.err_count_out);  assign o_first[2] = 32'(if2.first_err_cycle_out);
    assign o_chk[3] = 32'(if3.check_count_out);  assign o_err[3] = 32'(if3.err_count_out);  assign o_first[3] = 32'(if3.first_err_cycle_out);

    // Per-instance configuration as seen by the model.
    int p_max  [4] = '{65535, 65535, 65535, 15};
    int p_stop [4] = '{0, 0, 1, 0};
    int p_prio [4] = '{1, 0, 1, 1};

    // Model: phase 0 idle, 1 priming, 2 checking, 3 done.
    int m_phase [4], m_exp [4], m_chk [4], m_err [4], m_first [4], m_fail [4];

    function automatic int ref_next(input logic dd, input logic rl, input logic pr, input int prio);
        if (!rl && pr) return (prio != 0) ? 0 : 1;
        if (!rl)       return 0;
        if (pr)        return 1;
        return int'(dd);
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_phase[i] = 0; m_exp[i] = 0; m_chk[i] = 0;
                m_err[i] = 0; m_first[i] = 0; m_fail[i] = 0;
            end else begin
                int nxt;
                nxt = ref_next(d, ral, pre, p_prio[i]);
                case (m_phase[i])
                    0, 3: if (en) m_phase[i] = 1;
                    1: begin
                        m_chk[i] = 0; m_err[i] = 0; m_first[i] = 0; m_fail[i] = 0;
                        m_exp[i] = nxt;
                        m_phase[i] = en ? 2 : 0;
                    end
                    default: begin
                        if (!en) begin
                            m_phase[i] = 3;
                        end else begin
                            bit bad;
                            bad = (int'(qv[i]) != m_exp[i]);
                            if (bad) begin
                                if (m_fail[i] == 0) begin
                                    m_first[i] = m_chk[i];
                                    m_fail[i]  = 1;
                                end
                                m_err[i] = sat_inc(m_err[i], p_max[i]);
                                if (p_stop[i] != 0) m_phase[i] = 3;
                            end
                            m_chk[i] = sat_inc(m_chk[i], p_max[i]);
                        end
                        m_exp[i] = nxt;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[u%0d] at %0t: got %0d, required %0d", name, idx, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (running) begin
            for (int i = 0; i < 4; i++) begin
                chk("busy",  i, int'(o_busy[i]), (m_phase[i] == 1 || m_phase[i] == 2) ? 1 : 0);
                chk("pass",  i, int'(o_pass[i]), (m_phase[i] == 3 && m_err[i] == 0) ? 1 : 0);
                chk("fail",  i, int'(o_fail[i]), m_fail[i]);
                chk("exp_q", i, int'(o_exp[i]),  m_exp[i]);
                chk("check_count", i, int'(o_chk[i]),   m_chk[i]);
                chk("err_count",   i, int'(o_err[i]),   m_err[i]);
                chk("first_err",   i, int'(o_first[i]), m_first[i]);
            end
        end
    end

    // Inputs change on the falling edge; q follows each model's expectation, optionally flipped.
    task automatic drive(input logic e, input logic dd, input logic rl, input logic pr, input logic [3:0] flip);
        @(negedge clk);
        en = e; d = dd; ral = rl; pre = pr;
        for (int i = 0; i < 4; i++) qv[i] = m_exp[i][0] ^ flip[i];
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) qv[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 0, int'(o_busy[0]), 0);
        chk("rst_count", 0, int'(o_chk[0]), 0);
        chk("rst_exp", 0, int'(o_exp[0]), 0);
        rst = 1'b0;
        idle(2);

        // Happy path: priming edge, then 20 comparisons, then enable drops.
        for (int j = 0; j < 22; j++) drive(1'b1, j[0], 1'b1, 1'b0, 4'b0000);
        idle(2);
        chk("happy_count", 0, int'(o_chk[0]), 20);
        chk("happy_err",   0, int'(o_err[0]), 0);
        chk("happy_pass",  0, int'(o_pass[0]), 1);
        chk("happy_fail",  0, int'(o_fail[0]), 0);
        chk("happy_sat",   3, int'(o_chk[3]), 15);

        // u0 error at comparison 7, u2 stops at comparison 3, u3 always wrong.
        for (int j = 0; j < 22; j++) begin
            drive(1'b1, j[0], 1'b1, 1'b0, {j >= 2, j == 4, 1'b0, j == 8});
            if (j == 5) begin
                chk("stop_count", 2, int'(o_chk[2]), 3);
                chk("stop_err",   2, int'(o_err[2]), 1);
                chk("stop_busy",  2, int'(o_busy[2]), 0);
            end
        end
        idle(2);
        chk("err1_err",   0, int'(o_err[0]), 1);
        chk("err1_first", 0, int'(o_first[0]), 6);
        chk("err1_fail",  0, int'(o_fail[0]), 1);
        chk("err1_pass",  0, int'(o_pass[0]), 0);
        chk("sat_err",    3, int'(o_err[3]), 15);
        chk("sat_count",  3, int'(o_chk[3]), 15);

        // Reset and preset together.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        for (int j = 1; j < 8; j++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 4'b0000);
            if (j == 2) begin
                chk("prio_exp", 0, int'(o_exp[0]), 0);
                chk("prio_exp", 1, int'(o_exp[1]), 1);
            end
        end
        idle(2);
        chk("prio_err", 0, int'(o_err[0]), 0);
        chk("prio_err", 1, int'(o_err[1]), 0);

        // Random sessions, including ones that abort in the priming cycle.
        for (int s = 0; s < 12; s++) begin
            int len;
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                logic [3:0] fl;
                for (int i = 0; i < 4; i++) fl[i] = ($urandom_range(0, 15) == 0);
                drive(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) == 0), fl);
            end
            idle($urandom_range(1, 4));
        end

        // Asynchronous reset between edges in the middle of a session.
        for (int j = 0; j < 10; j++) drive(1'b1, j[0], 1'b1, 1'b0, 4'b0000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("arst_busy",  i, int'(o_busy[i]), 0);
            chk("arst_pass",  i, int'(o_pass[i]), 0);
            chk("arst_fail",  i, int'(o_fail[i]), 0);
            chk("arst_count", i, int'(o_chk[i]), 0);
            chk("arst_err",   i, int'(o_err[i]), 0);
        end
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        idle(3);

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
